// File: rtl/uart_tx_framer.sv
// UART transmitter with internal baud-tick counter, configurable payload width,
// parity mode and stop-bit count; valid/ready upstream, registered serial line.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clock_100MHz,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] TX_data,
  input  logic                 TX_valid,
  output logic                 TX_ready,
  output logic                 TXD,
  output logic                 TX_busy,
  output logic                 TX_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);
  // Mode 3 (and anything else) falls back to no parity.
  localparam logic        HAS_PAR   = (PARITY == 1) || (PARITY == 2);
  localparam logic        ODD_PAR   = (PARITY == 2);

  state_t                 state;
  state_t                 state_next;
  logic [15:0]            baud_cnt;
  logic [3:0]             bit_idx;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_bit;
  logic                   bit_tick;
  logic                   handshake;
  logic                   line_next;
  logic                   done_next;
  logic                   txd_r;
  logic                   done_r;

  assign bit_tick  = (baud_cnt == LAST_CNT);
  assign TX_ready  = (state == S_IDLE);
  assign TX_busy   = (state != S_IDLE);
  assign handshake = TX_valid && TX_ready;
  assign TXD       = txd_r;
  assign TX_done   = done_r;

  always_ff @(posedge Clock_100MHz) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (TX_valid) state_next = S_START;
      S_START:  if (bit_tick) state_next = S_DATA;
      S_DATA: begin
        if (bit_tick && (bit_idx == LAST_DATA)) begin
          state_next = HAS_PAR ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: if (bit_tick) state_next = S_STOP;
      S_STOP:   if (bit_tick && (bit_idx == LAST_STOP)) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Line level for the state in force this cycle; it reaches TXD one edge later,
  // which is what puts the start bit on the edge after the handshake.
  always_comb begin
    line_next = 1'b1;
    done_next = 1'b0;
    case (state)
      S_START:  line_next = 1'b0;
      S_DATA:   line_next = shift[0];
      S_PARITY: line_next = par_bit;
      S_STOP:   done_next = bit_tick && (bit_idx == LAST_STOP);
      default:  line_next = 1'b1;
    endcase
  end

  always_ff @(posedge Clock_100MHz) begin
    if (Reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      txd_r    <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      txd_r  <= line_next;
      done_r <= done_next;

      if ((state == S_IDLE) || bit_tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end

      if (state_next != state) begin
        bit_idx <= '0;
      end else if (bit_tick && ((state == S_DATA) || (state == S_STOP))) begin
        bit_idx <= bit_idx + 4'd1;
      end

      if (handshake) begin
        shift   <= TX_data;
        par_bit <= (^TX_data) ^ ODD_PAR;
      end else if ((state == S_DATA) && bit_tick) begin
        shift <= shift >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: an 8N1 instance and a 7-bit odd-parity,
// two-stop-bit instance, both at four clocks per bit.
module tb_uart_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_a;
  logic       valid_a, ready_a, txd_a, busy_a, done_a;
  logic [6:0] data_b;
  logic       valid_b, ready_b, txd_b, busy_b, done_b;

  uart_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .Clock_100MHz(clk), .Reset(rst), .TX_data(data_a), .TX_valid(valid_a),
    .TX_ready(ready_a), .TXD(txd_a), .TX_busy(busy_a), .TX_done(done_a)
  );

  uart_tx_framer #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut_b (
    .Clock_100MHz(clk), .Reset(rst), .TX_data(data_b), .TX_valid(valid_b),
    .TX_ready(ready_b), .TXD(txd_b), .TX_busy(busy_b), .TX_done(done_b)
  );

  int checks   = 0;
  int failures = 0;

  logic hist      [0:127];
  logic rdy_hist  [0:127];
  logic busy_hist [0:127];
  logic done_hist [0:127];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input int sel, input logic [8:0] d);
    int n;
    @(negedge clk);
    if (sel == 0) begin
      data_a = d[7:0]; valid_a = 1'b1;
    end else begin
      data_b = d[6:0]; valid_b = 1'b1;
    end
    n = 0;
    while (!((sel == 0) ? ready_a : ready_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  // Called right after the handshake edge; index k is the k-th cycle after it.
  task automatic record(input int sel, input int n, input int drop_at,
                        input bit scramble, input logic [8:0] d0);
    @(negedge clk);
    hist[0] = (sel == 0) ? txd_a : txd_b;
    if (sel == 0) data_a = d0[7:0]; else data_b = d0[6:0];
    if (drop_at == 0) begin
      valid_a = 1'b0; valid_b = 1'b0;
    end
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      hist[k]      = (sel == 0) ? txd_a   : txd_b;
      rdy_hist[k]  = (sel == 0) ? ready_a : ready_b;
      busy_hist[k] = (sel == 0) ? busy_a  : busy_b;
      done_hist[k] = (sel == 0) ? done_a  : done_b;
      if (scramble) begin
        data_a = 8'($urandom);
        data_b = 7'($urandom);
      end
      if (k == drop_at) begin
        valid_a = 1'b0; valid_b = 1'b0;
      end
    end
  endtask

  task automatic decode(input int start, input int nbits,
                        output logic [15:0] frame, output int glitches);
    frame = '0;
    glitches = 0;
    for (int i = 0; i < nbits; i++) begin
      frame[i] = hist[start + i*4];
      for (int c = 1; c < 4; c++) begin
        if (hist[start + i*4 + c] !== frame[i]) glitches++;
      end
    end
  endtask

  task automatic done_scan(input int from, input int to, output int cnt, output int last);
    cnt = 0;
    last = -1;
    for (int k = from; k <= to; k++) begin
      if (done_hist[k] === 1'b1) begin
        cnt++;
        last = k;
      end
    end
  endtask

  task automatic idle_scan(input int from, input int to, output int bad);
    bad = 0;
    for (int k = from; k <= to; k++) begin
      if (hist[k] !== 1'b1) bad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] frame;
    int glitches, cnt, last, bad, f1, f2;

    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0;    data_b = '0;

    // Reset sequence
    @(posedge clk);
    @(negedge clk);
    check("rst_txd",   {31'd0, txd_a},   32'd1);
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    check("rst_busy",  {31'd0, busy_a},  32'd0);
    check("rst_done",  {31'd0, done_a},  32'd0);
    check("rst_b_line", {29'd0, txd_b, ready_b, busy_b}, 32'b110);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
      if (txd_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0 || done_b !== 1'b0) bad++;
    end
    check("idle_after_rst", bad, 0);

    // Reset together with TX_valid: no frame may start
    @(negedge clk);
    rst = 1'b1; valid_a = 1'b1; data_a = 8'hFF;
    @(negedge clk);
    rst = 1'b0; valid_a = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check("rst_beats_valid", bad, 0);

    // Single 8N1 frame of 0xA5: {stop, data, start} = 0x34A
    start_frame(0, 9'h0A5);
    record(0, 44, 0, 1'b0, 9'h0A5);
    check("a5_txd_cycle0", {31'd0, hist[0]}, 32'd1);
    check("a5_txd_cycle1", {31'd0, hist[1]}, 32'd0);
    decode(1, 10, frame, glitches);
    check("a5_frame", {16'd0, frame}, 32'h34A);
    check("a5_hold", glitches, 0);
    done_scan(1, 44, cnt, last);
    check("a5_done_count", cnt, 1);
    check("a5_done_cycle", last, 40);
    check("a5_busy_cycle1", {31'd0, busy_hist[1]}, 32'd1);
    check("a5_ready_cycle39", {31'd0, rdy_hist[39]}, 32'd0);
    check("a5_ready_cycle40", {31'd0, rdy_hist[40]}, 32'd1);
    idle_scan(41, 44, bad);
    check("a5_idle_after", bad, 0);

    // 7O2 frame of 0x41: {stop, stop, parity=1, data, start} = 0x782, 44 cycles
    start_frame(1, 9'h041);
    record(1, 48, 0, 1'b0, 9'h041);
    decode(1, 11, frame, glitches);
    check("p41_frame", {16'd0, frame}, 32'h782);
    check("p41_hold", glitches, 0);
    done_scan(1, 48, cnt, last);
    check("p41_done_count", cnt, 1);
    check("p41_done_cycle", last, 44);
    check("p41_ready_cycle43", {31'd0, rdy_hist[43]}, 32'd0);
    idle_scan(45, 48, bad);
    check("p41_idle_after", bad, 0);

    // Back-to-back with TX_valid held: 0x00 then 0xFF
    start_frame(0, 9'h000);
    record(0, 84, 41, 1'b0, 9'h0FF);
    f1 = -1;
    for (int k = 1; k <= 84; k++) if (f1 < 0 && hist[k] === 1'b0) f1 = k;
    f2 = -1;
    for (int k = 41; k <= 84; k++) if (f2 < 0 && hist[k] === 1'b0) f2 = k;
    check("b2b_first_start", f1, 1);
    check("b2b_spacing", f2 - f1, 41);
    decode(1, 10, frame, glitches);
    check("b2b_frame0", {16'd0, frame}, 32'h200);
    decode(42, 10, frame, glitches);
    check("b2b_frame1", {16'd0, frame}, 32'h3FE);
    done_scan(1, 84, cnt, last);
    check("b2b_done_count", cnt, 2);
    check("b2b_done_last", last, 81);

    // Mid-frame abort during data bit 3 of 0x3C
    start_frame(0, 9'h03C);
    record(0, 18, 0, 1'b0, 9'h03C);
    check("abort_bit1", {31'd0, hist[9]}, 32'd0);
    check("abort_bit3", {31'd0, hist[17]}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_txd",   {31'd0, txd_a},   32'd1);
    check("abort_ready", {31'd0, ready_a}, 32'd1);
    check("abort_busy",  {31'd0, busy_a},  32'd0);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (txd_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    check("abort_stays_idle", bad, 0);
    start_frame(0, 9'h03C);
    record(0, 44, 0, 1'b0, 9'h03C);
    decode(1, 10, frame, glitches);
    check("abort_next_frame", {16'd0, frame}, 32'h278);
    check("abort_next_hold", glitches, 0);
    done_scan(1, 44, cnt, last);
    check("abort_next_done", last, 40);

    // TX_data scrambled every cycle after the handshake of 0x96
    start_frame(0, 9'h096);
    record(0, 44, 0, 1'b1, 9'h096);
    decode(1, 10, frame, glitches);
    check("iso_frame", {16'd0, frame}, 32'h32C);
    check("iso_hold", glitches, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
